// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle load hazard unit: address width
// default, legal load-latency range, scoreboard entry layout and the
// per-cycle pipeline control decision.
package hazard_pkg;

    localparam int unsigned HZ_AW_DEFAULT    = 5;
    localparam int unsigned HZ_AW_MAX        = 8;
    localparam int unsigned HZ_LOAD_LAT_MIN  = 1;
    localparam int unsigned HZ_LOAD_LAT_MAX  = 4;

    // One in-flight load whose data is not yet forwardable. The address
    // field is sized for the widest supported AW; narrower AW is zero-extended.
    typedef struct packed {
        logic                 valid;
        logic [HZ_AW_MAX-1:0] wa;
    } sb_entry_t;

    // Pipeline control decision for the current cycle, highest priority first:
    // reset, redirect flush, load-use stall, normal flow.
    typedef enum logic [1:0] {
        CTL_IDLE  = 2'd0,
        CTL_RUN   = 2'd1,
        CTL_STALL = 2'd2,
        CTL_FLUSH = 2'd3
    } hz_ctl_e;

    function automatic logic hz_lat_ok(input int unsigned lat);
        return (lat >= HZ_LOAD_LAT_MIN) && (lat <= HZ_LOAD_LAT_MAX);
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Tracks loads that have left EX but whose data is still LOAD_LAT-1 cycles
// away from being forwardable, and flags ID sources that depend on them
// (or on a qualifying load currently in EX).
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned AW       = HZ_AW_DEFAULT,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_id_rs,
    input  logic [AW-1:0] i_id_rt,
    input  logic          i_id_rs_used,
    input  logic          i_id_rt_used,
    input  logic          i_ex_valid,
    input  logic          i_ex_mem_read,
    input  logic          i_ex_reg_write,
    input  logic [AW-1:0] i_ex_wa,
    output logic          o_rs_match,
    output logic          o_rt_match
);

    localparam int unsigned DEPTH = LOAD_LAT - 1;

    logic w_ex_load;
    logic w_sb_rs_hit;
    logic w_sb_rt_hit;

    // A load in EX that writes a real (nonzero) register
    assign w_ex_load = i_ex_valid & i_ex_mem_read & i_ex_reg_write & (i_ex_wa != '0);

    generate
        if (DEPTH > 0) begin : g_sb
            sb_entry_t r_sb [DEPTH];

            // Shift register of in-flight loads; keeps moving during stall/flush
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_sb[k].valid <= 1'b0;
                    end
                end else begin
                    r_sb[0].valid <= w_ex_load;
                    r_sb[0].wa    <= HZ_AW_MAX'(i_ex_wa);
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_sb[k] <= r_sb[k-1];
                    end
                end
            end

            // Any valid entry writing a requested source register
            always_comb begin
                w_sb_rs_hit = 1'b0;
                w_sb_rt_hit = 1'b0;
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (r_sb[k].valid && (r_sb[k].wa == HZ_AW_MAX'(i_id_rs))) begin
                        w_sb_rs_hit = 1'b1;
                    end
                    if (r_sb[k].valid && (r_sb[k].wa == HZ_AW_MAX'(i_id_rt))) begin
                        w_sb_rt_hit = 1'b1;
                    end
                end
            end
        end else begin : g_nosb
            logic w_unused;
            assign w_unused    = &{1'b0, i_clk, i_rst};
            assign w_sb_rs_hit = 1'b0;
            assign w_sb_rt_hit = 1'b0;
        end
    endgenerate

    assign o_rs_match = i_id_rs_used & (i_id_rs != '0) &
                        ((w_ex_load & (i_ex_wa == i_id_rs)) | w_sb_rs_hit);
    assign o_rt_match = i_id_rt_used & (i_id_rt != '0) &
                        ((w_ex_load & (i_ex_wa == i_id_rt)) | w_sb_rt_hit);

endmodule

// File: rtl/hazard_unit_mc.sv
// Load-use hazard unit with configurable load latency. Stalls ID while a
// source depends on a load whose data is not yet forwardable; a taken
// branch flushes instead and overrides the stall.
// Optional statistics counters are built only with HAZARD_STATS_EN defined.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned AW       = HZ_AW_DEFAULT,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [AW-1:0]     ex_wa,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              stall,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_cycles
);

    logic    w_rs_match;
    logic    w_rt_match;
    logic    w_match;
    hz_ctl_e w_ctl;

    load_scoreboard #(
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_rs_used   (id_rs_used),
        .i_id_rt_used   (id_rt_used),
        .i_ex_valid     (ex_valid),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_wa        (ex_wa),
        .o_rs_match     (w_rs_match),
        .o_rt_match     (w_rt_match)
    );

    assign w_match = w_rs_match | w_rt_match;

    // Prioritised control decision: reset, then flush, then stall
    always_comb begin
        w_ctl = CTL_RUN;
        if (rst) begin
            w_ctl = CTL_IDLE;
        end else if (branch_taken) begin
            w_ctl = CTL_FLUSH;
        end else if (w_match) begin
            w_ctl = CTL_STALL;
        end
    end

    // Decode the decision into pipeline control strobes
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        unique case (w_ctl)
            CTL_STALL: begin
                stall       = 1'b1;
                pc_write    = 1'b0;
                idex_bubble = 1'b1;
            end
            CTL_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_ctl == CTL_STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((w_ctl == CTL_FLUSH) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_cycles = r_flush_cnt;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: one instance at LOAD_LAT=1 and one at
// LOAD_LAT=3 with 4-bit counters. Directed cycles push hand-computed
// expectations; per-instance monitors pop and compare at the falling edge.
module tb_hazard_unit_mc;

    localparam logic [3:0] IDLE = 4'b0100;  // {stall, pc_write, ifid_flush, idex_bubble}
    localparam logic [3:0] STL  = 4'b1001;
    localparam logic [3:0] FLS  = 4'b0111;
    localparam logic [2:0] LD   = 3'b111;   // {ex_valid, ex_mem_read, ex_reg_write}
    localparam logic [2:0] NOP  = 3'b000;

    typedef struct {
        logic [3:0]  o;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q1[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] m1_sc = 0, m1_fc = 0, m3_sc = 0, m3_fc = 0;

    logic       a_rst = 1'b1, a_rsu = 1'b0, a_rtu = 1'b0, a_exv = 1'b0, a_exm = 1'b0, a_exw = 1'b0, a_br = 1'b0;
    logic [4:0] a_rs = '0, a_rt = '0, a_wa = '0;
    logic       a_pcw, a_fl, a_bub, a_st;
    logic [31:0] a_sc, a_fc;

    logic       b_rst = 1'b1, b_rsu = 1'b0, b_rtu = 1'b0, b_exv = 1'b0, b_exm = 1'b0, b_exw = 1'b0, b_br = 1'b0;
    logic [4:0] b_rs = '0, b_rt = '0, b_wa = '0;
    logic       b_pcw, b_fl, b_bub, b_st;
    logic [3:0] b_sc, b_fc;

    hazard_unit_mc #(.AW(5), .LOAD_LAT(1), .STAT_W(32)) u1 (
        .clk(clk), .rst(a_rst), .id_rs(a_rs), .id_rt(a_rt),
        .id_rs_used(a_rsu), .id_rt_used(a_rtu), .ex_valid(a_exv),
        .ex_mem_read(a_exm), .ex_reg_write(a_exw), .ex_wa(a_wa),
        .branch_taken(a_br), .pc_write(a_pcw), .ifid_flush(a_fl),
        .idex_bubble(a_bub), .stall(a_st), .stall_cycles(a_sc), .flush_cycles(a_fc)
    );

    hazard_unit_mc #(.AW(5), .LOAD_LAT(3), .STAT_W(4)) u3 (
        .clk(clk), .rst(b_rst), .id_rs(b_rs), .id_rt(b_rt),
        .id_rs_used(b_rsu), .id_rt_used(b_rtu), .ex_valid(b_exv),
        .ex_mem_read(b_exm), .ex_reg_write(b_exw), .ex_wa(b_wa),
        .branch_taken(b_br), .pc_write(b_pcw), .ifid_flush(b_fl),
        .idex_bubble(b_bub), .stall(b_st), .stall_cycles(b_sc), .flush_cycles(b_fc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] mx);
        return (v == mx) ? v : v + 32'd1;
    endfunction

    // One cycle of stimulus for instance d (1 or 3) plus its expected response
    task automatic cyc(input int d, input logic r,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic [2:0] ex, input logic [4:0] wa,
                       input logic br, input logic [3:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        x.o = e;
`ifdef HAZARD_STATS_EN
        x.sc = (d == 1) ? m1_sc : m3_sc;
        x.fc = (d == 1) ? m1_fc : m3_fc;
`else
        x.sc = 32'd0;
        x.fc = 32'd0;
`endif
        if (d == 1) begin
            a_rst = r; a_rs = rs; a_rsu = rsu; a_rt = rt; a_rtu = rtu;
            {a_exv, a_exm, a_exw} = ex; a_wa = wa; a_br = br;
            q1.push_back(x);
            if (r) begin
                m1_sc = 0; m1_fc = 0;
            end else begin
                if (e[3]) m1_sc = sat_inc(m1_sc, 32'hFFFF_FFFF);
                if (br)   m1_fc = sat_inc(m1_fc, 32'hFFFF_FFFF);
            end
        end else begin
            b_rst = r; b_rs = rs; b_rsu = rsu; b_rt = rt; b_rtu = rtu;
            {b_exv, b_exm, b_exw} = ex; b_wa = wa; b_br = br;
            q3.push_back(x);
            if (r) begin
                m3_sc = 0; m3_fc = 0;
            end else begin
                if (e[3]) m3_sc = sat_inc(m3_sc, 32'd15);
                if (br)   m3_fc = sat_inc(m3_fc, 32'd15);
            end
        end
    endtask

    // Monitor for the LOAD_LAT=1 instance
    always @(negedge clk) begin
        exp_t x;
        if (q1.size() > 0) begin
            x = q1.pop_front();
            check("u1_ctl", 32'({a_st, a_pcw, a_fl, a_bub}), 32'(x.o));
            check("u1_stall_cycles", a_sc, x.sc);
            check("u1_flush_cycles", a_fc, x.fc);
        end
    end

    // Monitor for the LOAD_LAT=3 instance
    always @(negedge clk) begin
        exp_t x;
        if (q3.size() > 0) begin
            x = q3.pop_front();
            check("u3_ctl", 32'({b_st, b_pcw, b_fl, b_bub}), 32'(x.o));
            check("u3_stall_cycles", 32'(b_sc), x.sc);
            check("u3_flush_cycles", 32'(b_fc), x.fc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- LOAD_LAT = 1 ----------------
        cyc(1, 1, 5'd5, 1, 5'd0, 0, LD,  5'd5, 0, IDLE);   // reset masks a live match
        cyc(1, 1, 5'd5, 1, 5'd0, 0, LD,  5'd5, 1, IDLE);   // reset masks branch too
        cyc(1, 0, 5'd5, 1, 5'd0, 0, LD,  5'd5, 0, STL);    // classic load-use on rs
        cyc(1, 0, 5'd5, 1, 5'd0, 0, NOP, 5'd0, 0, IDLE);   // one cycle only
        cyc(1, 0, 5'd0, 1, 5'd0, 1, LD,  5'd0, 0, IDLE);   // load to $0, reads $0
        cyc(1, 0, 5'd6, 0, 5'd3, 1, LD,  5'd6, 0, IDLE);   // rs match but not used
        cyc(1, 0, 5'd4, 1, 5'd0, 0, 3'b101, 5'd4, 0, IDLE); // ALU write, not a load
        cyc(1, 0, 5'd4, 1, 5'd0, 0, 3'b011, 5'd4, 0, IDLE); // EX not valid
        cyc(1, 0, 5'd0, 0, 5'd4, 1, 3'b110, 5'd4, 0, IDLE); // load without reg write
        cyc(1, 0, 5'd2, 1, 5'd9, 1, LD,  5'd9, 0, STL);    // rt match
        cyc(1, 0, 5'd5, 1, 5'd0, 0, LD,  5'd5, 1, FLS);    // branch overrides stall
        cyc(1, 0, 5'd0, 0, 5'd0, 0, NOP, 5'd0, 0, IDLE);
        cyc(1, 0, 5'd10, 1, 5'd10, 1, LD, 5'd10, 0, STL);  // both sources match
        cyc(1, 0, 5'd0, 0, 5'd0, 0, NOP, 5'd0, 0, IDLE);
        @(posedge clk); #1;
        a_rst = 1'b1;

        // ---------------- LOAD_LAT = 3, STAT_W = 4 ----------------
        cyc(3, 1, 5'd0, 0, 5'd0, 0, NOP, 5'd0, 0, IDLE);
        cyc(3, 0, 5'd0, 0, 5'd7, 1, LD,  5'd7, 0, STL);    // three-cycle load-use on rt
        cyc(3, 0, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, IDLE);   // stall_cycles now 3
        cyc(3, 0, 5'd8, 1, 5'd0, 0, LD,  5'd8, 1, FLS);    // flush, load still tracked
        cyc(3, 0, 5'd8, 1, 5'd0, 0, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd8, 1, 5'd0, 0, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd8, 1, 5'd0, 0, NOP, 5'd0, 0, IDLE);
        cyc(3, 0, 5'd0, 1, 5'd0, 1, LD,  5'd0, 0, IDLE);   // $0 never tracked
        cyc(3, 0, 5'd0, 1, 5'd0, 1, NOP, 5'd0, 0, IDLE);
        cyc(3, 0, 5'd0, 0, 5'd7, 1, LD,  5'd7, 0, STL);    // stall cycle 1
        cyc(3, 1, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, IDLE);   // reset in cycle 2
        cyc(3, 0, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, IDLE);   // scoreboard was cleared
        cyc(3, 0, 5'd0, 0, 5'd7, 1, NOP, 5'd0, 0, IDLE);
        for (int i = 0; i < 20; i++) begin
            cyc(3, 0, 5'd3, 1, 5'd0, 0, LD, 5'd3, 0, STL); // drive counter into saturation
        end
        cyc(3, 0, 5'd3, 1, 5'd0, 0, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd3, 1, 5'd0, 0, NOP, 5'd0, 0, STL);
        cyc(3, 0, 5'd3, 1, 5'd0, 0, NOP, 5'd0, 0, IDLE);
        cyc(3, 0, 5'd0, 0, 5'd0, 0, NOP, 5'd0, 1, FLS);
        cyc(3, 0, 5'd0, 0, 5'd0, 0, NOP, 5'd0, 0, IDLE);

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(q1.size() + q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
